// File: rtl/execute_stage_mext_pkg.sv
// Shared types for the RV32IM execute stage: control word, ALU/MDU opcodes,
// forwarding selects and operand-signedness helpers for the M extension.
package execute_stage_mext_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Encoded as the RISC-V funct3 of the M-extension instructions.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2,
    FWD_RF_ALT = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic    alu_src;
    alu_op_t alu_op;
    mdu_op_t mdu_op;
    logic    is_mdu;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } control_type;

  function automatic logic mdu_is_div(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic mdu_a_signed(input mdu_op_t op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic mdu_b_signed(input mdu_op_t op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/execute_stage_mext_if.sv
// Bundle of ID/EX inputs, forwarding sources and EX/MEM-facing results of the
// execute stage; slave is the stage itself, master is whoever drives it.
interface execute_stage_mext_if
  import execute_stage_mext_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            valid_in;
  logic            flush;
  control_type     control_in;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] immediate_data;
  fwd_sel_t        fwd_a_sel;
  fwd_sel_t        fwd_b_sel;
  logic [XLEN-1:0] ex_mem_data;
  logic [XLEN-1:0] mem_wb_data;
  control_type     control_out;
  logic            valid_out;
  logic            stall_out;
  logic            zero_flag;
  logic [XLEN-1:0] alu_data;
  logic [XLEN-1:0] memory_data;
  logic            illegal_op;

  modport master (
    output valid_in, flush, control_in, data1, data2, immediate_data,
           fwd_a_sel, fwd_b_sel, ex_mem_data, mem_wb_data,
    input  control_out, valid_out, stall_out, zero_flag, alu_data,
           memory_data, illegal_op
  );

  modport slave (
    input  valid_in, flush, control_in, data1, data2, immediate_data,
           fwd_a_sel, fwd_b_sel, ex_mem_data, mem_wb_data,
    output control_out, valid_out, stall_out, zero_flag, alu_data,
           memory_data, illegal_op
  );
endinterface

// File: rtl/execute_stage_mext_mdu_iterative.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied on the DONE cycle.
module mdu_iterative
  import execute_stage_mext_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  mdu_op_t           op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              div0_q, div0_d;

  logic              a_sgn, b_sgn, issue_div, issue_div0;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   quo, rem;

  assign a_sgn      = mdu_a_signed(op) & a[XLEN-1];
  assign b_sgn      = mdu_b_signed(op) & b[XLEN-1];
  assign a_mag      = a_sgn ? -a : a;
  assign b_mag      = b_sgn ? -b : b;
  assign issue_div  = mdu_is_div(op);
  assign issue_div0 = issue_div & (b == '0);

  // acc holds {hi, lo}: product bits for multiply, {remainder, quotient} for divide.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    a_d       = a_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_BUSY;
          op_d      = op;
          a_d       = a;
          neg_d     = a_sgn ^ b_sgn;
          rem_neg_d = a_sgn;
          div0_d    = issue_div0;
          count_d   = (DIV0_FAST && issue_div0) ? '0 : CW'(XLEN - 1);
          opnd_d    = issue_div ? b_mag : a_mag;
          acc_d     = {{XLEN{1'b0}}, (issue_div ? a_mag : b_mag)};
        end
      end
      S_BUSY: begin
        acc_d   = mdu_is_div(op_q) ? div_next : mul_next;
        count_d = count_q - 1'b1;
        if (flush)               state_d = S_IDLE;
        else if (count_q == '0)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      op_q      <= MDU_MUL;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      a_q       <= a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign prod = neg_q ? -acc_q : acc_q;
  assign quo  = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  // Divide-by-zero bypasses the datapath; signed overflow falls out of the magnitudes.
  always_comb begin
    result = '0;
    case (op_q)
      MDU_MUL:                        result = acc_q[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              result = div0_q ? '1 : (neg_q ? -quo : quo);
      default:                        result = div0_q ? a_q : (rem_neg_q ? -rem : rem);
    endcase
  end

  assign idle = (state_q == S_IDLE);
  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);

endmodule

// File: rtl/execute_stage_mext.sv
// RV32IM execute stage: operand forwarding, single-cycle ALU and an optional
// iterative MDU whose busy period stalls the upstream pipeline.
module execute_stage_mext
  import execute_stage_mext_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter bit MDU_EN    = 1'b1,
  parameter bit DIV0_FAST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  execute_stage_mext_if.slave ex
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, right_operand, alu_res, mdu_result;
  logic            mdu_idle, mdu_busy, mdu_done, mdu_start, m_op;

  always_comb begin
    case (ex.fwd_a_sel)
      FWD_EX_MEM: fwd_a = ex.ex_mem_data;
      FWD_MEM_WB: fwd_a = ex.mem_wb_data;
      default:    fwd_a = ex.data1;
    endcase
    case (ex.fwd_b_sel)
      FWD_EX_MEM: fwd_b = ex.ex_mem_data;
      FWD_MEM_WB: fwd_b = ex.mem_wb_data;
      default:    fwd_b = ex.data2;
    endcase
  end

  assign right_operand = ex.control_in.alu_src ? ex.immediate_data : fwd_b;

  always_comb begin
    case (ex.control_in.alu_op)
      ALU_SUB:  alu_res = fwd_a - right_operand;
      ALU_AND:  alu_res = fwd_a & right_operand;
      ALU_OR:   alu_res = fwd_a | right_operand;
      ALU_XOR:  alu_res = fwd_a ^ right_operand;
      ALU_SLL:  alu_res = fwd_a << right_operand[SHW-1:0];
      ALU_SRL:  alu_res = fwd_a >> right_operand[SHW-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(fwd_a) >>> right_operand[SHW-1:0]);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(right_operand))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < right_operand)};
      default:  alu_res = fwd_a + right_operand;
    endcase
  end

  generate
    if (MDU_EN) begin : g_mdu
      // Reset also masks the issue request so stall_out drops with rst, not at an edge.
      assign mdu_start = ex.valid_in & ex.control_in.is_mdu & ~ex.flush & ~rst;
      mdu_iterative #(
        .XLEN      (XLEN),
        .DIV0_FAST (DIV0_FAST)
      ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .flush  (ex.flush),
        .op     (ex.control_in.mdu_op),
        .a      (fwd_a),
        .b      (fwd_b),
        .idle   (mdu_idle),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
      );
    end else begin : g_no_mdu
      assign mdu_start  = 1'b0;
      assign mdu_idle   = 1'b1;
      assign mdu_busy   = 1'b0;
      assign mdu_done   = 1'b0;
      assign mdu_result = '0;
    end
  endgenerate

  assign m_op           = ex.control_in.is_mdu;
  assign ex.stall_out   = (mdu_start & mdu_idle) | mdu_busy;
  assign ex.valid_out   = mdu_done ? ~ex.flush
                        : (mdu_idle & ex.valid_in & ~ex.flush & (~m_op | ~MDU_EN));
  assign ex.illegal_op  = ~MDU_EN & ex.valid_in & ~ex.flush & m_op;
  assign ex.alu_data    = mdu_done ? mdu_result : (m_op ? '0 : alu_res);
  assign ex.zero_flag   = ex.valid_out & ~mdu_done & ~m_op & (alu_res == '0);
  assign ex.memory_data = fwd_b;
  assign ex.control_out = ex.valid_out ? ex.control_in : '0;

endmodule

// File: tb/tb_execute_stage_mext.sv
// Directed bench for execute_stage_mext: forwarding, ALU ops, MDU results and
// latency, divide corner cases, flush and asynchronous reset mid-operation.
module tb_execute_stage_mext;
  import execute_stage_mext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  execute_stage_mext_if #(.XLEN(32)) ex_if ();

  execute_stage_mext #(
    .XLEN      (32),
    .MDU_EN    (1'b1),
    .DIV0_FAST (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_if.valid_in       = 1'b0;
    ex_if.flush          = 1'b0;
    ex_if.control_in     = '0;
    ex_if.data1          = '0;
    ex_if.data2          = '0;
    ex_if.immediate_data = '0;
    ex_if.fwd_a_sel      = FWD_RF;
    ex_if.fwd_b_sel      = FWD_RF;
    ex_if.ex_mem_data    = '0;
    ex_if.mem_wb_data    = '0;
  endtask

  task automatic alu_case(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_imm, input logic [31:0] exp);
    control_type ctl;
    @(posedge clk); #1;
    ctl = '0;
    ctl.alu_op = op;
    ctl.alu_src = use_imm;
    ctl.reg_write = 1'b1;
    ex_if.control_in     = ctl;
    ex_if.valid_in       = 1'b1;
    ex_if.data1          = a;
    ex_if.data2          = use_imm ? 32'h0000_0055 : b;
    ex_if.immediate_data = use_imm ? b : 32'h0000_00AA;
    #4;
    check({tag, "_data"}, ex_if.alu_data, exp);
    check({tag, "_valid"}, 32'(ex_if.valid_out), 32'd1);
    check({tag, "_zero"}, 32'(ex_if.zero_flag), (exp == 32'd0) ? 32'd1 : 32'd0);
    check({tag, "_stall"}, 32'(ex_if.stall_out), 32'd0);
    $display("[TB] %s a=0x%08h b=0x%08h -> 0x%08h", tag, a, b, ex_if.alu_data);
  endtask

  task automatic run_mdu(input string tag, input mdu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
    control_type ctl;
    int          cyc;
    int          stall_cnt;
    logic        seen;
    logic [31:0] res;
    logic [31:0] ctl_seen;
    @(posedge clk); #1;
    ctl = '0;
    ctl.is_mdu = 1'b1;
    ctl.mdu_op = op;
    ctl.reg_write = 1'b1;
    ex_if.control_in = ctl;
    ex_if.valid_in   = 1'b1;
    ex_if.data1      = a;
    ex_if.data2      = b;
    cyc = 0; stall_cnt = 0; seen = 1'b0; res = '0; ctl_seen = '0;
    while (!seen && cyc <= 40) begin
      #4;
      if (ex_if.valid_out) begin
        seen = 1'b1;
        res = ex_if.alu_data;
        ctl_seen = 32'(ex_if.control_out);
        check({tag, "_stall_done"}, 32'(ex_if.stall_out), 32'd0);
      end else if (ex_if.stall_out) begin
        stall_cnt++;
      end
      if (!seen) begin
        @(posedge clk); #1;
        cyc++;
        if (cyc == 1) begin
          // operands were captured at issue; later forwarding must not matter
          ex_if.fwd_a_sel   = FWD_EX_MEM;
          ex_if.fwd_b_sel   = FWD_EX_MEM;
          ex_if.ex_mem_data = 32'h1234_5678;
        end
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_result"}, res, exp);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_stalls"}, stall_cnt, exp_cyc);
    check({tag, "_ctl"}, ctl_seen, 32'(ctl));
    $display("[TB] %s a=0x%08h b=0x%08h -> 0x%08h at cycle %0d", tag, a, b, res, cyc);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    control_type ctl;
    int          vo_cnt;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(ex_if.stall_out), 32'd0);
    check("rst_valid", 32'(ex_if.valid_out), 32'd0);
    check("rst_illegal", 32'(ex_if.illegal_op), 32'd0);
    check("rst_ctl", 32'(ex_if.control_out), 32'd0);
    rst = 1'b0;

    // Forwarding into operand A, then operand B as store data
    @(posedge clk); #1;
    ctl = '0; ctl.alu_op = ALU_ADD; ctl.reg_write = 1'b1;
    ex_if.control_in = ctl; ex_if.valid_in = 1'b1;
    ex_if.data1 = 32'd5; ex_if.data2 = 32'd1; ex_if.ex_mem_data = 32'd9;
    ex_if.fwd_a_sel = FWD_EX_MEM;
    #4;
    check("fwd_exmem", ex_if.alu_data, 32'd10);
    check("fwd_ctl", 32'(ex_if.control_out), 32'(ctl));
    $display("[TB] fwd_exmem -> %0d", ex_if.alu_data);
    @(posedge clk); #1;
    ex_if.fwd_a_sel = FWD_MEM_WB; ex_if.mem_wb_data = 32'd3;
    ex_if.fwd_b_sel = FWD_EX_MEM;
    #4;
    check("fwd_memwb", ex_if.alu_data, 32'd12);
    check("fwd_store", ex_if.memory_data, 32'd9);
    $display("[TB] fwd_memwb -> %0d", ex_if.alu_data);
    @(posedge clk); #1;
    ex_if.fwd_b_sel = FWD_RF;
    #4;
    check("fwd_memwb_rf", ex_if.alu_data, 32'd4);
    check("store_rf", ex_if.memory_data, 32'd1);
    $display("[TB] fwd_memwb_rf -> %0d", ex_if.alu_data);
    @(posedge clk); #1;
    idle_inputs();

    alu_case("sub_imm", ALU_SUB, 32'd5, 32'd5, 1'b1, 32'd0);
    alu_case("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
    alu_case("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
    alu_case("sra", ALU_SRA, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    alu_case("sll", ALU_SLL, 32'd1, 32'd31, 1'b0, 32'h8000_0000);
    alu_case("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 1'b0, 32'hFF00_0000);
    @(posedge clk); #1;
    idle_inputs();

    run_mdu("mul", MDU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33);
    run_mdu("mulh", MDU_MULH, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 33);
    run_mdu("mulhsu", MDU_MULHSU, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 33);
    run_mdu("mulhu", MDU_MULHU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 33);
    run_mdu("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mdu("rem", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mdu("divu", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run_mdu("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_mdu("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_mdu("divu_0", MDU_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 2);
    run_mdu("remu_0", MDU_REMU, 32'd10, 32'd0, 32'd10, 2);
    run_mdu("rem_0", MDU_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);

    // Flush on cycle 10 of a divide
    @(posedge clk); #1;
    ctl = '0; ctl.is_mdu = 1'b1; ctl.mdu_op = MDU_DIV;
    ex_if.control_in = ctl; ex_if.valid_in = 1'b1;
    ex_if.data1 = 32'd100; ex_if.data2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    ex_if.flush = 1'b1;
    #4;
    check("flush_valid", 32'(ex_if.valid_out), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    #4;
    check("flush_stall", 32'(ex_if.stall_out), 32'd0);
    vo_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ex_if.valid_out) vo_cnt++;
    end
    check("flush_no_valid", vo_cnt, 32'd0);
    $display("[TB] flush_div valid pulses after flush = %0d", vo_cnt);
    alu_case("add_after_flush", ALU_ADD, 32'd2, 32'd3, 1'b0, 32'd5);
    @(posedge clk); #1;
    idle_inputs();

    // Asynchronous reset in the middle of a MULHU
    @(posedge clk); #1;
    ctl = '0; ctl.is_mdu = 1'b1; ctl.mdu_op = MDU_MULHU;
    ex_if.control_in = ctl; ex_if.valid_in = 1'b1;
    ex_if.data1 = 32'hFFFF_FFFF; ex_if.data2 = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(ex_if.stall_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_stall", 32'(ex_if.stall_out), 32'd0);
    check("rst_async_valid", 32'(ex_if.valid_out), 32'd0);
    $display("[TB] rst mid-mulhu stall_out=%0b", ex_if.stall_out);
    @(posedge clk); #1;
    idle_inputs();
    #2;
    rst = 1'b0;
    run_mdu("mul_after_rst", MDU_MUL, 32'd6, 32'd7, 32'd42, 33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
